// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: byte width, receiver state encoding and
// small helpers used by the receiver and its tick generator.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state for 8E1).
package uart_pkg;

  localparam int BYTE_W = 8;

  // Receiver FSM states. PARITY exists only when even parity is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks per oversample tick; integer division, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  // Parity bit value that makes the total count of ones even.
  function automatic logic even_parity(input logic [BYTE_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversample tick every DIV clocks.
// With DIV=1 the tick is permanently high (one tick per clock).
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter wraps at DIV-1 and never stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// one-byte holding register presented as a valid/ready stream.
//
// Handshake: o_valid/o_data describe a held byte; a transfer happens on any
// rising clk edge where o_valid & i_ready. o_data never changes while o_valid
// is high except when a new byte lands in the same cycle as a transfer.
// i_ready has no influence on reception timing.
//
// o_state exposes the receiver FSM state for observation.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic              o_parity_err,
`endif
  output logic              o_busy,
  output rx_state_e         o_state
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  // Tick index of the start-bit centre and of each following bit centre.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic              tick;
  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic              rx_fall;
  rx_state_e         state;
  logic [TW-1:0]     tick_cnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic              parity_bad;
`endif

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A start needs a high-to-low transition, so after a low stop bit the
  // receiver naturally waits for the line to return high first.
  assign rx_fall = rx_prev & ~rx_sync;

  // Receiver FSM, sample counters and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      // Consumer takes the held byte; a byte landing this cycle overrides.
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_fall) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              // Line back high at the start-bit centre: treat as a glitch.
              state    <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {rx_sync, shift[BYTE_W-1:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt   <= '0;
              parity_bad <= even_parity(shift) ^ rx_sync;
              state      <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              if (!rx_sync) begin
                o_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (parity_bad) begin
                o_parity_err <= 1'b1;
`endif
              end else if (!o_valid || i_ready) begin
                o_data  <= shift;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream at 16 clk per bit (CLK_FREQ=16M, BAUD=1M, OS=16).
// Define UART_RX_PARITY_EN for both RTL and bench to exercise 8E1.
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 16_000_000;
  localparam int BAUD_RATE  = 1_000_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 16;

  logic       clk;
  logic       rst_n;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif
  logic       o_busy;
  rx_state_e  o_state;

  uart_rx_stream #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int check_cnt;
  int pass_cnt;
  int valid_cycles;
  int ferr_cnt;
  int ovr_cnt;
  int perr_cnt;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    i_rx = 1'b0;
    wait_cycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      wait_cycles(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par;
    wait_cycles(BIT_CLKS);
`else
    if (par === 1'bx) i_rx = 1'b1;
`endif
    i_rx = stop;
    wait_cycles(BIT_CLKS);
    i_rx = 1'b1;
  endtask

  // ---------------- main ----------------
  initial begin
    int f0, o0, v0, p0;
    int waited;
    check_cnt = 0;
    pass_cnt = 0;
    valid_cycles = 0;
    ferr_cnt = 0;
    ovr_cnt = 0;
    perr_cnt = 0;
    rst_n = 1'b0;
    i_rx = 1'b1;
    i_ready = 1'b0;

    // Monitor: counts pulses and pops the scoreboard on each transfer.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (o_valid) valid_cycles++;
          if (o_frame_err) ferr_cnt++;
          if (o_overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
          if (o_parity_err) perr_cnt++;
`endif
          if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_byte", 32'(o_data), 32'hFFFF_FFFF);
            end else begin
              chk("rx_data", 32'(o_data), 32'(exp_q.pop_front()));
            end
          end
        end
      end
    join_none

    wait_cycles(3);
    chk("reset_outputs", 32'({o_data, o_valid, o_frame_err, o_overrun, o_busy}), 32'd0);
    chk("reset_state", 32'(o_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_cycles(5);

    // Table of single frames: {data, stop bit, ready, expect byte, expect frame errors}.
    vecs[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 0};
    vecs[4] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1};

    for (int k = 0; k < 6; k++) begin
      f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
      i_ready = vecs[k].ready;
      if (vecs[k].exp_valid) exp_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, even_parity(vecs[k].data), vecs[k].stop);
      wait_cycles(20);
      chk("vec_frame_err", 32'(ferr_cnt - f0), 32'(vecs[k].exp_ferr));
      chk("vec_overrun", 32'(ovr_cnt - o0), 32'd0);
      chk("vec_valid_cycles", 32'(valid_cycles - v0), vecs[k].exp_valid ? 32'd1 : 32'd0);
      chk("vec_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Start glitch: line low 4 cycles then high; no byte, busy clears quickly.
    v0 = valid_cycles;
    i_rx = 1'b0;
    wait_cycles(4);
    chk("glitch_busy_seen", 32'(o_busy), 32'd1);
    i_rx = 1'b1;
    waited = 0;
    while (o_busy && waited < 30) begin
      wait_cycles(1);
      waited++;
    end
    chk("glitch_busy_within_9", 32'(waited <= 9), 32'd1);
    wait_cycles(20);
    chk("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);

    // Overrun: two bytes with consumer stalled, then drain.
    o0 = ovr_cnt;
    i_ready = 1'b0;
    exp_q.push_back(8'h0B);
    send_frame(8'h0B, even_parity(8'h0B), 1'b1);
    wait_cycles(4);
    send_frame(8'h11, even_parity(8'h11), 1'b1);
    wait_cycles(20);
    chk("ovr_pulse_count", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_data_held", 32'(o_data), 32'h0B);
    chk("ovr_valid_held", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    wait_cycles(5);
    chk("ovr_drained", 32'(exp_q.size()), 32'd0);
    chk("ovr_valid_drop", 32'(o_valid), 32'd0);

    // Reset in the middle of data bit 4 of 0x7E.
    v0 = valid_cycles;
    i_rx = 1'b0;
    wait_cycles(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      i_rx = (i == 0) ? 1'b0 : 1'b1;
      wait_cycles(BIT_CLKS);
    end
    i_rx = 1'b1;
    wait_cycles(8);
    chk("mid_frame_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero", 32'({o_data, o_valid, o_frame_err, o_overrun, o_busy}), 32'd0);
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(4);
    exp_q.push_back(8'h01);
    send_frame(8'h01, even_parity(8'h01), 1'b1);
    wait_cycles(20);
    chk("rst_then_byte_done", 32'(exp_q.size()), 32'd0);
    chk("rst_then_one_valid", 32'(valid_cycles - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Even parity: wrong parity bit drops the byte, correct one delivers it.
    p0 = perr_cnt; v0 = valid_cycles;
    send_frame(8'h07, 1'b0, 1'b1);
    wait_cycles(20);
    chk("par_err_pulse", 32'(perr_cnt - p0), 32'd1);
    chk("par_err_no_valid", 32'(valid_cycles - v0), 32'd0);
    p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cycles(20);
    chk("par_ok_no_err", 32'(perr_cnt - p0), 32'd0);
    chk("par_ok_delivered", 32'(exp_q.size()), 32'd0);
`else
    p0 = perr_cnt;
    chk("no_parity_pulses", 32'(p0), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
